// File: rtl/reg_rr_arbiter.sv
// reg_rr_arbiter: round-robin ownership arbiter and write controller for a
// single shared WIDTH-bit register. N requesters compete; only the current
// grantee may load the register. Grants are registered one-hot. A requester
// that releases hands over to the next pending requester with no idle cycle.
// A hold limit forces rotation when others are waiting.
//
// Handshake (req/gnt): a requester raises req and holds it high for as long as
// it wants ownership. gnt[i] rises one edge after it wins arbitration and stays
// high while req[i] stays high, unless the hold limit moves it away. A write
// happens at any edge where gnt[i] & req[i] & we[i]. Dropping req[i] releases
// ownership at that same edge, and a write presented at that edge is discarded.
module reg_rr_arbiter #(
   parameter int N       = 4,
   parameter int WIDTH   = 8,
   parameter int OWNER_W = 2,
   parameter int MAXHOLD = 4
) (
   input  logic                 clk,
   input  logic                 r,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         we,
   input  logic [N*WIDTH-1:0]   wdata,
   output logic [N-1:0]         gnt,
   output logic [OWNER_W-1:0]   owner,
   output logic                 busy,
   output logic [WIDTH-1:0]     q,
   output logic                 dbg_state
);

   localparam int HOLD_W = $clog2(MAXHOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAXHOLD);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   state_t               state_q;
   logic [N-1:0]         gnt_q;
   logic [OWNER_W-1:0]   owner_q;
   logic                 busy_q;
   logic [WIDTH-1:0]     q_q;
   logic [OWNER_W-1:0]   ptr_q;
   logic [HOLD_W-1:0]    hold_q;

   logic [N-1:0]         cand;
   logic                 found;
   logic [OWNER_W-1:0]   pick;
   int                   idx;
   logic [OWNER_W-1:0]   ptr_d;
   logic [N-1:0]         gnt_d;
   logic                 wr_en;
   logic [WIDTH-1:0]     wsel;

   // Candidate search: first pending requester starting at ptr, wrapping mod N.
   // While owned, the current owner is masked out so a forced move or a release
   // always lands on somebody else.
   always_comb begin
      cand  = req;
      if (state_q == ST_OWN) begin
         cand = req & ~gnt_q;
      end
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_q) + k) % N;
         if (!found && cand[idx]) begin
            found = 1'b1;
            pick  = OWNER_W'(idx);
         end
      end
   end

   // New-grant vector, next priority pointer and the write path of the owner.
   always_comb begin
      gnt_d = {{(N-1){1'b0}}, 1'b1} << pick;
      ptr_d = (pick == OWNER_W'(N - 1)) ? '0 : pick + 1'b1;
      wr_en = gnt_q[owner_q] & req[owner_q] & we[owner_q];
      wsel  = wdata[int'(owner_q)*WIDTH +: WIDTH];
   end

   // Ownership FSM with registered grant outputs and the shared data register.
   always_ff @(posedge clk) begin
      if (r) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         q_q     <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         if (wr_en) begin
            q_q <= wsel;
         end
         case (state_q)
            ST_IDLE: begin
               if (found) begin
                  state_q <= ST_OWN;
                  gnt_q   <= gnt_d;
                  owner_q <= pick;
                  busy_q  <= 1'b1;
                  ptr_q   <= ptr_d;
                  hold_q  <= HOLD_W'(1);
               end
            end
            ST_OWN: begin
               if (!req[owner_q]) begin
                  // Release: hand straight over if anyone else is waiting.
                  if (found) begin
                     gnt_q   <= gnt_d;
                     owner_q <= pick;
                     ptr_q   <= ptr_d;
                     hold_q  <= HOLD_W'(1);
                  end else begin
                     state_q <= ST_IDLE;
                     gnt_q   <= '0;
                     busy_q  <= 1'b0;
                     hold_q  <= '0;
                  end
               end else if (hold_q == HOLD_MAX && found) begin
                  // Hold limit reached with a waiter: force rotation.
                  gnt_q   <= gnt_d;
                  owner_q <= pick;
                  ptr_q   <= ptr_d;
                  hold_q  <= HOLD_W'(1);
               end else if (hold_q != HOLD_MAX) begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign owner     = owner_q;
   assign busy      = busy_q;
   assign q         = q_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// tb_reg_rr_arbiter: directed-vector bench for reg_rr_arbiter (N=4, WIDTH=8,
// MAXHOLD=4). Expected values are hand-derived from the arbitration rules.
module tb_reg_rr_arbiter;

   localparam int N       = 4;
   localparam int WIDTH   = 8;
   localparam int OWNER_W = 2;
   localparam int MAXHOLD = 4;

   logic                 clk;
   logic                 r;
   logic [N-1:0]         req;
   logic [N-1:0]         we;
   logic [N*WIDTH-1:0]   wdata;
   logic [N-1:0]         gnt;
   logic [OWNER_W-1:0]   owner;
   logic                 busy;
   logic [WIDTH-1:0]     q;
   logic                 dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   reg_rr_arbiter #(
      .N(N), .WIDTH(WIDTH), .OWNER_W(OWNER_W), .MAXHOLD(MAXHOLD)
   ) dut (
      .clk(clk), .r(r), .req(req), .we(we), .wdata(wdata),
      .gnt(gnt), .owner(owner), .busy(busy), .q(q), .dbg_state(dbg_state)
   );

   // Clock and timeout
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One active edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wd(input int i, input logic [WIDTH-1:0] v);
      wdata[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic check_all(input string tag, input logic [N-1:0] e_gnt,
                            input logic [OWNER_W-1:0] e_owner, input logic e_busy,
                            input logic [WIDTH-1:0] e_q);
      check({tag, "_gnt"}, 32'(gnt), 32'(e_gnt));
      if (e_busy) check({tag, "_owner"}, 32'(owner), 32'(e_owner));
      check({tag, "_busy"}, 32'(busy), 32'(e_busy));
      check({tag, "_q"}, 32'(q), 32'(e_q));
   endtask

   logic [WIDTH-1:0] d [N];
   int               seq [4];
   int               prev;

   initial begin
      r     = 1'b1;
      req   = 4'b1111;
      we    = 4'b1111;
      wdata = '1;

      // Reset dominates requests and writes
      tick();
      check_all("rst", 4'b0000, 2'd0, 1'b0, 8'h00);
      check("rst_state", 32'(dbg_state), 32'd0);
      r = 1'b0;
      tick();
      check_all("first_gnt", 4'b0001, 2'd0, 1'b1, 8'h00);
      check("first_state", 32'(dbg_state), 32'd1);
      req = 4'b0000;
      we  = 4'b0000;
      tick();
      check_all("back_idle", 4'b0000, 2'd0, 1'b0, 8'h00);

      // Single requester from idle (ptr=1 now)
      req = 4'b0100;
      we  = 4'b0100;
      set_wd(2, 8'hA5);
      tick();
      check_all("single_gnt", 4'b0100, 2'd2, 1'b1, 8'h00);
      tick();
      check_all("single_wr", 4'b0100, 2'd2, 1'b1, 8'hA5);

      // Write from a non-granted requester is ignored
      we = 4'b0010;
      set_wd(1, 8'h3C);
      tick();
      check_all("ignored_wr", 4'b0100, 2'd2, 1'b1, 8'hA5);

      // Release with 1 and 3 pending: ptr=3 so 3 wins, zero-bubble
      req = 4'b1010;
      we  = 4'b0000;
      tick();
      check_all("handover_ptr", 4'b1000, 2'd3, 1'b1, 8'hA5);
      req = 4'b1000;
      we  = 4'b1000;
      set_wd(3, 8'hC3);
      tick();
      check_all("own3_wr", 4'b1000, 2'd3, 1'b1, 8'hC3);

      // Release without contention; write at the release edge is dropped
      req = 4'b0000;
      set_wd(3, 8'h5A);
      tick();
      check_all("release", 4'b0000, 2'd0, 1'b0, 8'hC3);
      check("release_state", 32'(dbg_state), 32'd0);

      // Round robin with hold limit: req=1011, ptr=0, everyone writing
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h00; d[3] = 8'h44;
      for (int i = 0; i < N; i++) set_wd(i, d[i]);
      seq  = '{0, 1, 3, 0};
      req  = 4'b1011;
      we   = 4'b1011;
      tick();
      prev = -1;
      for (int c = 0; c < 16; c++) begin
         logic [N-1:0] eg;
         eg = '0;
         eg[seq[c/4]] = 1'b1;
         check_all($sformatf("rr_c%0d", c), eg, OWNER_W'(seq[c/4]), 1'b1,
                   (prev < 0) ? 8'hC3 : d[prev]);
         prev = seq[c/4];
         if (c < 15) tick();
      end

      // Owner 0 releases, 1 takes over and writes
      req = 4'b0010;
      we  = 4'b0010;
      set_wd(1, 8'h55);
      tick();
      check_all("to_owner1", 4'b0010, 2'd1, 1'b1, 8'h11);
      tick();
      check_all("owner1_wr", 4'b0010, 2'd1, 1'b1, 8'h55);

      // Reset mid-ownership; re-grant searches from index 0
      r   = 1'b1;
      req = 4'b0110;
      we  = 4'b0110;
      set_wd(2, 8'h99);
      tick();
      check_all("mid_rst", 4'b0000, 2'd0, 1'b0, 8'h00);
      r = 1'b0;
      tick();
      check_all("regrant", 4'b0010, 2'd1, 1'b1, 8'h00);
      tick();
      check_all("regrant_wr", 4'b0010, 2'd1, 1'b1, 8'h55);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
